// File: rtl/rf_pkg.sv
// Shared definitions for the register-file writeback path: address width,
// the x0 encoding and the default requester count.
package rf_pkg;

  localparam int REG_ADDR_W  = 5;
  localparam int DEF_XLEN    = 32;
  localparam int DEF_NUM_REQ = 3;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DEF_XLEN-1:0]   data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first valid requester found
// searching upward from ptr_i with wrap modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o
);

  int   idx;
  logic found;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // Explicit wrap keeps non-power-of-two requester counts in range.
      idx = int'(ptr_i) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found && (j == idx) && valid_i[j]) begin
          grant_o[j] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the single register-file write port among NUM_REQ writeback sources
// with round-robin arbitration, a registered write command and a contention counter.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int XLEN    = DEF_XLEN,
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int CNT_W   = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  input  logic [NUM_REQ*5-1:0]    req_rd_i,
  input  logic [NUM_REQ*XLEN-1:0] req_data_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  output logic                    rf_we_o,
  output logic [4:0]              rf_rd_o,
  output logic [XLEN-1:0]         rf_din_o,
  output logic [CNT_W-1:0]        conflict_cnt_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic                  we_q, we_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0]       din_q, din_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [NUM_REQ-1:0]    arb_valid;
  logic [NUM_REQ-1:0]    grant;
  logic [REG_ADDR_W-1:0] sel_rd;
  logic [XLEN-1:0]       sel_data;
  logic [3:0]            n_valid;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Reset and flush mask the request vector so ready can never rise.
  assign arb_valid = (rst_i || flush_i) ? '0 : req_valid_i;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .valid_i (arb_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant)
  );

  assign req_ready_o = grant;

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    ptr_d    = ptr_q;
    n_valid  = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      n_valid = n_valid + 4'(req_valid_i[j]);
      if (grant[j]) begin
        sel_rd   = req_rd_i[j*REG_ADDR_W +: REG_ADDR_W];
        sel_data = req_data_i[j*XLEN +: XLEN];
        ptr_d    = (j == NUM_REQ - 1) ? '0 : PTR_W'(j + 1);
      end
    end
  end

  // x0 writes are consumed but never reach the register file.
  always_comb begin
    we_d  = (|grant) && (sel_rd != ZERO_REG);
    rd_d  = we_d ? sel_rd : rd_q;
    din_d = we_d ? sel_data : din_q;
    cnt_d = (!flush_i && (n_valid >= 4'd2)) ? sat_inc(cnt_q) : cnt_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
      we_q  <= 1'b0;
      rd_q  <= '0;
      din_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      we_q  <= we_d;
      rd_q  <= rd_d;
      din_q <= din_d;
      cnt_q <= cnt_d;
    end
  end

  assign rf_we_o        = we_q;
  assign rf_rd_o        = rd_q;
  assign rf_din_o       = din_q;
  assign conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: a driver pushes expectations from a
// behavioural model, a monitor pops and compares each cycle.
module tb_rf_wb_arbiter;

  localparam int N   = 3;
  localparam int XL  = 32;
  localparam int CW  = 16;
  localparam int CWS = 4;
  localparam int SAT_MAX = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_i, flush_i;
  logic [N-1:0]      req_valid_i;
  logic [N*5-1:0]    req_rd_i;
  logic [N*XL-1:0]   req_data_i;

  logic [N-1:0]      ready, ready_s;
  logic              we, we_s;
  logic [4:0]        rd, rd_s;
  logic [XL-1:0]     din, din_s;
  logic [CW-1:0]     cnt;
  logic [CWS-1:0]    cnt_s;

  rf_wb_arbiter #(.XLEN(XL), .NUM_REQ(N), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_rd_i(req_rd_i), .req_data_i(req_data_i),
    .req_ready_o(ready), .rf_we_o(we), .rf_rd_o(rd), .rf_din_o(din),
    .conflict_cnt_o(cnt)
  );

  rf_wb_arbiter #(.XLEN(XL), .NUM_REQ(N), .CNT_W(CWS)) dut_sat (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_rd_i(req_rd_i), .req_data_i(req_data_i),
    .req_ready_o(ready_s), .rf_we_o(we_s), .rf_rd_o(rd_s), .rf_din_o(din_s),
    .conflict_cnt_o(cnt_s)
  );

  typedef struct {
    logic          we;
    logic [4:0]    rd;
    logic [XL-1:0] din;
    int            cnt;
  } out_t;

  logic [N-1:0] q_rdy[$];
  out_t         q_out[$];

  int checks = 0;
  int errors = 0;

  // Stimulus state: each requester holds its request until accepted.
  logic          st_rst, st_flush;
  logic [N-1:0]  st_valid;
  logic [4:0]    st_rd[N];
  logic [XL-1:0] st_data[N];

  // Reference model state.
  int            m_ptr;
  logic          m_we;
  logic [4:0]    m_rd;
  logic [XL-1:0] m_din;
  int            m_cnt;

  task automatic do_cycle();
    int g;
    logic [N-1:0] er;
    out_t o;
    @(negedge clk);
    rst_i       = st_rst;
    flush_i     = st_flush;
    req_valid_i = st_valid;
    for (int i = 0; i < N; i++) begin
      req_rd_i[i*5 +: 5]    = st_rd[i];
      req_data_i[i*XL +: XL] = st_data[i];
    end
    g  = -1;
    er = '0;
    if (!st_rst && !st_flush) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (g < 0 && st_valid[i]) g = i;
      end
    end
    for (int j = 0; j < N; j++) if (j == g) er[j] = 1'b1;
    q_rdy.push_back(er);

    if (st_rst) begin
      m_ptr = 0; m_we = 1'b0; m_rd = '0; m_din = '0; m_cnt = 0;
    end else if (st_flush) begin
      m_we = 1'b0;
    end else begin
      if ($countones(st_valid) >= 2) m_cnt++;
      m_we = 1'b0;
      if (g >= 0) begin
        m_ptr = (g + 1) % N;
        if (st_rd[g] != 5'd0) begin
          m_we  = 1'b1;
          m_rd  = st_rd[g];
          m_din = st_data[g];
        end
      end
    end
    o.we = m_we; o.rd = m_rd; o.din = m_din; o.cnt = m_cnt;
    q_out.push_back(o);
    for (int j = 0; j < N; j++) if (j == g) st_valid[j] = 1'b0;
  endtask

  task automatic refill(input logic [N-1:0] mask, input int rd_base);
    for (int i = 0; i < N; i++) begin
      if (mask[i] && !st_valid[i]) begin
        st_valid[i] = 1'b1;
        st_rd[i]    = 5'(rd_base + i);
        st_data[i]  = $urandom;
      end
    end
  endtask

  // Monitor: ready sampled mid-cycle, registered outputs just after the edge.
  initial begin
    logic [N-1:0] er;
    out_t o;
    int sat_exp;
    forever begin
      @(negedge clk);
      #2;
      if (q_rdy.size() > 0) begin
        er = q_rdy.pop_front();
        checks++;
        if (ready !== er || ready_s !== er) begin
          errors++;
          $display("FAIL ready act=%b/%b exp=%b t=%0t", ready, ready_s, er, $time);
        end
      end
      @(posedge clk);
      #1;
      if (q_out.size() > 0) begin
        o = q_out.pop_front();
        checks++;
        if (we !== o.we || rd !== o.rd || din !== o.din ||
            we_s !== o.we || rd_s !== o.rd || din_s !== o.din) begin
          errors++;
          $display("FAIL wrcmd act=%b/%0d/%h exp=%b/%0d/%h t=%0t",
                   we, rd, din, o.we, o.rd, o.din, $time);
        end
        checks++;
        if (cnt !== CW'(o.cnt)) begin
          errors++;
          $display("FAIL conflict_cnt act=%0d exp=%0d t=%0t", cnt, o.cnt, $time);
        end
        sat_exp = (o.cnt > SAT_MAX) ? SAT_MAX : o.cnt;
        checks++;
        if (cnt_s !== CWS'(sat_exp)) begin
          errors++;
          $display("FAIL conflict_cnt_sat act=%0d exp=%0d t=%0t", cnt_s, sat_exp, $time);
        end
      end
    end
  end

  initial begin
    int t;
    rst_i = 1'b1; flush_i = 1'b0;
    req_valid_i = '0; req_rd_i = '0; req_data_i = '0;
    m_ptr = 0; m_we = 1'b0; m_rd = '0; m_din = '0; m_cnt = 0;
    st_rst = 1'b1; st_flush = 1'b0; st_valid = '0;
    for (int i = 0; i < N; i++) begin st_rd[i] = '0; st_data[i] = '0; end

    // Reset held with every requester valid.
    refill('1, 10);
    repeat (2) do_cycle();
    st_rst = 1'b0;

    // Fairness: all valid for six cycles, refilled on acceptance.
    for (int c = 0; c < 6; c++) begin
      refill('1, 10);
      do_cycle();
    end
    st_valid = '0;
    do_cycle();

    // Single requester 1.
    st_valid = 3'b010; st_rd[1] = 5'd5; st_data[1] = 32'hDEADBEEF;
    do_cycle();
    do_cycle();

    // x0 write from requester 0.
    st_valid = 3'b001; st_rd[0] = 5'd0; st_data[0] = 32'h0000_1234;
    do_cycle();
    do_cycle();

    // Flush with requester 2 pending, then normal grant.
    st_valid = 3'b100; st_rd[2] = 5'd7; st_data[2] = 32'hCAFE_0007;
    st_flush = 1'b1;
    do_cycle();
    st_flush = 1'b0;
    do_cycle();
    do_cycle();

    // Two requesters contending long enough to saturate the 4-bit counter.
    for (int c = 0; c < 20; c++) begin
      refill(3'b011, 20);
      do_cycle();
    end
    st_valid = '0;
    do_cycle();

    // Randomized traffic with occasional flush and mid-run reset.
    for (int c = 0; c < 400; c++) begin
      st_rst   = ($urandom_range(0, 63) == 0);
      st_flush = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < N; i++) begin
        if (!st_valid[i] && $urandom_range(0, 1) == 1) begin
          st_valid[i] = 1'b1;
          st_rd[i]    = 5'($urandom_range(0, 31));
          st_data[i]  = $urandom;
        end
      end
      do_cycle();
    end
    st_rst = 1'b0; st_flush = 1'b0; st_valid = '0;
    repeat (2) do_cycle();

    t = 0;
    while (t < 20 && (q_out.size() > 0 || q_rdy.size() > 0)) begin
      @(posedge clk);
      t++;
    end
    @(negedge clk);
    if (q_out.size() > 0 || q_rdy.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain left=%0d/%0d exp=0", q_out.size(), q_rdy.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port among NUM_REQ writeback sources (e.g. ALU, load unit, multi-cycle mul/div).
- Uses valid/ready handshakes and round-robin arbitration.
- Drives a registered write command (rd, data, we) into the register file.
- Sits between the execute/memory writeback stages and the register file write port; also reports arbitration contention.

Parameters:
- XLEN, 32, data width of writeback values.
- NUM_REQ, 3, number of writeback requesters (2..8).
- CNT_W, 16, width of the saturating contention counter.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- flush_i  in  1  synchronous pipeline flush.
- req_valid_i  in  NUM_REQ  requester i has a write pending.
- req_rd_i  in  NUM_REQ*5  destination register of requester i, packed, [5i+4:5i].
- req_data_i  in  NUM_REQ*XLEN  write data of requester i, packed.
- req_ready_o  out  NUM_REQ  one-hot grant/accept to requester i.
- rf_we_o  out  1  register file write enable.
- rf_rd_o  out  5  register file destination address.
- rf_din_o  out  XLEN  register file write data.
- conflict_cnt_o  out  CNT_W  saturating count of contended cycles.

Behaviour:
- Clock/reset: one clock. Reset is synchronous, active-high on rst_i, sampled at the clk_i rising edge. Reset and flush_i are both synchronous.
- Reset values:
  - rf_we_o=0, rf_rd_o=0, rf_din_o=0, conflict_cnt_o=0.
  - Round-robin pointer=0, so requester 0 has highest priority first.
  - req_ready_o=0 while rst_i=1.
- Handshake:
  - A transfer occurs on a cycle where req_valid_i[i] && req_ready_o[i].
  - The requester holds valid, rd and data stable until accepted.
  - req_ready_o is combinational from req_valid_i, the pointer and flush_i/rst_i. It is never asserted without the matching valid.
  - At most one ready bit is high per cycle.
- Arbitration:
  - Requesters are searched starting at the pointer, then pointer+1, ... mod NUM_REQ.
  - The first valid requester found is granted.
  - On a grant to requester g, the pointer becomes (g+1) mod NUM_REQ at the next edge.
  - With no grant, the pointer holds.
  - Every continuously-valid requester is granted within NUM_REQ cycles.
- Output register, 1-cycle latency:
  - Grant in cycle T => rf_we_o=1 in T+1, with rf_rd_o/rf_din_o = the granted rd/data.
  - With no grant in T => rf_we_o=0 in T+1. rf_rd_o/rf_din_o hold their previous values.
  - Full throughput: one write per cycle.
- x0 handling:
  - A granted request with rd=0 is accepted (ready=1) and the pointer advances.
  - rf_we_o stays 0 for that request; rf_rd_o/rf_din_o are not updated.
- Flush:
  - flush_i=1 forces req_ready_o=0 that cycle and forces rf_we_o=0 at the next edge.
  - The pointer holds and conflict_cnt_o holds.
  - Requests still valid after the flush re-arbitrate normally.
- Reset mid-operation: the output register is cleared and any accepted-but-unwritten transfer is dropped. Requesters must re-present.
- Contention counter:
  - Increments by 1 on each non-flush cycle with popcount(req_valid_i) >= 2.
  - Saturates at 2^CNT_W-1 with no wrap.
- Arithmetic: pointer is $clog2(NUM_REQ) bits. Wrap is explicit mod NUM_REQ, including non-power-of-two NUM_REQ, so no illegal pointer value is ever reached.

Decomposition:
- Package rf_pkg:
  - REG_ADDR_W=5.
  - Typedef wb_req_t {logic [4:0] rd; logic [XLEN-1:0] data}.
  - Constants ZERO_REG=5'd0 and default NUM_REQ.
- Sub-module rr_arbiter (NUM_REQ):
  - Inputs: valid vector, pointer. Output: one-hot grant.
  - Purely combinational, so it can be reused for other shared resources.
- rf_wb_arbiter instantiates rr_arbiter and owns the pointer, output register, flush logic and counter.

Test Plan:
- Reset: hold rst_i=1 for 2 cycles with all valids high -> req_ready_o=0, rf_we_o=0, conflict_cnt_o=0. After release, the first grant goes to requester 0.
- Single requester: req 1 valid, rd=5, data=0xDEADBEEF -> ready[1]=1 the same cycle. Next cycle rf_we_o=1, rf_rd_o=5, rf_din_o=0xDEADBEEF.
- Fairness: all 3 valid continuously for 6 cycles -> grant order 0,1,2,0,1,2. conflict_cnt_o=6. One write per cycle on rf_we_o.
- x0 drop: req 0 rd=0, data=0x1234 -> ready[0]=1 and the pointer advances to 1. rf_we_o stays 0 next cycle; rf_rd_o/rf_din_o unchanged.
- Flush: req 2 valid, flush_i=1 for 1 cycle -> ready[2]=0, rf_we_o=0 next cycle. With flush_i=0, req 2 is granted and its write appears 1 cycle later.
- Saturation: CNT_W=4, two requesters valid for 20 cycles -> conflict_cnt_o reaches 15 and holds.
